// File: rtl/cache_def.sv
// Shared types and constants for the direct-mapped cache: 1024 lines of 128 bits, 32-bit address.
package cache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE_TAG,
    ALLOCATE,
    WRITE_BACK
  } cache_state_type;

  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [TAGMSB-TAGLSB:0]   tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] sel);
    return line[sel*32 +: 32];
  endfunction

  function automatic cache_data_type merge_word(input cache_data_type line, input logic [1:0] sel,
                                                input logic [31:0] word);
    cache_data_type res;
    res = line;
    res[sel*32 +: 32] = word;
    return res;
  endfunction

endpackage

// File: rtl/dm_cache_fsm.sv
// Write-back, write-allocate controller for a direct-mapped cache; tag/data arrays live outside.
module dm_cache_fsm
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  input  mem_data_type   mem_res,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output cache_req_type  data_req,
  output cache_data_type data_write,
  input  cache_data_type data_read
);

  cache_state_type state, next_state;
  cpu_req_type     req_q;
  logic [31:0]     victim_addr;
  cache_data_type  victim_data;

  logic [TAGMSB-TAGLSB:0] req_tag;
  logic [9:0]             index;
  logic [1:0]             word;
  logic                   hit;

  assign req_tag = req_q.addr[TAGMSB:TAGLSB];
  assign index   = req_q.addr[13:4];
  assign word    = req_q.addr[3:2];
  assign hit     = tag_read.valid && (tag_read.tag == req_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      victim_addr <= '0;
      victim_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req.valid)
        req_q <= cpu_req;
      if (state == COMPARE_TAG && !hit) begin
        victim_addr <= {tag_read.tag, index, 4'h0};
        victim_data <= data_read;
      end
    end
  end

  // Outputs are gated by rst_n so a reset landing mid-refill cannot commit a partial update.
  always_comb begin
    next_state = state;
    cpu_res    = '0;
    mem_req    = '0;
    tag_req    = '{index: index, we: 1'b0};
    data_req   = '{index: index, we: 1'b0};
    tag_write  = '0;
    data_write = data_read;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (cpu_req.valid)
            next_state = COMPARE_TAG;
        end
        COMPARE_TAG: begin
          if (hit) begin
            cpu_res.ready = 1'b1;
            cpu_res.data  = get_word(data_read, word);
            if (req_q.rw) begin
              data_write   = merge_word(data_read, word, req_q.data);
              data_req.we  = 1'b1;
              tag_write    = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
              tag_req.we   = 1'b1;
            end
            next_state = IDLE;
          end else if (tag_read.valid && tag_read.dirty) begin
            next_state = WRITE_BACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
        WRITE_BACK: begin
          mem_req = '{addr: victim_addr, data: victim_data, rw: 1'b1, valid: 1'b1};
          if (mem_res.ready)
            next_state = ALLOCATE;
        end
        ALLOCATE: begin
          mem_req = '{addr: {req_tag, index, 4'h0}, data: '0, rw: 1'b0, valid: 1'b1};
          if (mem_res.ready) begin
            data_write  = mem_res.data;
            data_req.we = 1'b1;
            tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            tag_req.we  = 1'b1;
            next_state  = COMPARE_TAG;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule
